// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Read-side bus between the UART receive buffer and the Device register logic.
interface uart_rx_buffer_if #(
    parameter int FIFO_DEPTH = 4
);
    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      rd_en;
    logic                      clr_err;
    logic [UART_DATA_BITS-1:0] rd_data;
    logic                      rd_valid;
    logic [CW-1:0]             count;
    logic                      overrun;
    logic                      frame_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rd_valid, count, overrun, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rd_valid, count, overrun, frame_err
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through circular FIFO; pushes on a full FIFO and pops on an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    // Fullness is judged on the pre-pop occupancy, so a push into a full FIFO is lost even with a same-cycle pop.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive path: synchronizes rx, deframes 8N1 characters and queues them in a FWFT FIFO.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 110000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_buffer_if.slave bus
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = $clog2(DIV);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_meta_q, rx_meta_d;
    logic                      rx_s_q,    rx_s_d;
    logic                      rx_d_q,    rx_d_d;
    rx_state_t                 state_q,   state_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_err_q, frame_err_d;

    logic                      push;
    logic                      overrun_set;
    logic                      frame_set;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [UART_DATA_BITS-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.rd_en),
        .din   (shift_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rd_data   = fifo_dout;
    assign bus.rd_valid  = !fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        rx_d_d      = rx_s_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        overrun_set = 1'b0;
        frame_set   = 1'b0;

        case (state_q)
            // Only a high-to-low transition starts a frame, so a held break never retriggers.
            IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rx_s_q) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    if (rx_s_q) begin
                        if (!fifo_full) begin
                            push = 1'b1;
                        end else begin
                            overrun_set = 1'b1;
                        end
                    end else begin
                        frame_set = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error in the same cycle as a clear must still be reported.
        overrun_d = overrun_q;
        if (bus.clr_err) overrun_d = 1'b0;
        if (overrun_set) overrun_d = 1'b1;
        frame_err_d = frame_err_q;
        if (bus.clr_err) frame_err_d = 1'b0;
        if (frame_set)   frame_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_d_q      <= rx_d_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at DIV=10; each task drives one scenario and checks its own results.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD_RATE = 100;
    localparam int DEPTH     = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [2:0] cnt_pre;
    logic [2:0] cnt_post;
    int         compared   = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    uart_rx_buffer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_buffer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    // One frame is 100 cycles; the stop bit is sampled on the 98th rising edge after the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop,
                              input bit clr_at_stop, input int rst_at);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 97) cnt_pre = bus.count;
            if (c == 98) cnt_post = bus.count;
            if (c == rst_at) reset = 1'b0;
            bus.rd_en   = (c == 97) && pop_at_stop;
            bus.clr_err = (c == 97) && clr_at_stop;
            if (c / 10 == 0)      rx = 1'b0;
            else if (c / 10 == 9) rx = stop_bit;
            else                  rx = b[c / 10 - 1];
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset = 1'b1;
                rx    = 1'b1;
                break;
            end
        end
        if (rst_at < 0) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) bus.clr_err = 1'b1;
        @(negedge clk) bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        rx          = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        compared += 5;
        if (bus.rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
        if (bus.rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        if (bus.count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        compared += 5;
        if (cnt_pre !== 3'd0) begin mismatched++; $display("[TB] FAIL single_count_before_stop: got %0d expected 0", cnt_pre); end
        if (cnt_post !== 3'd1) begin mismatched++; $display("[TB] FAIL single_count_after_stop: got %0d expected 1", cnt_post); end
        if (bus.rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_rd_valid: got %b expected 1", bus.rd_valid); end
        if (bus.rd_data !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_rd_data: got %h expected a5", bus.rd_data); end
        if (bus.count !== 3'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", bus.count); end
        pop_one();
        compared += 3;
        if (bus.rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_pop_valid: got %b expected 0", bus.rd_valid); end
        if (bus.rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL single_pop_data: got %h expected 00", bus.rd_data); end
        if (bus.count !== 3'd0) begin mismatched++; $display("[TB] FAIL single_pop_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] v;
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i);
            send_frame(v, 1'b1, 1'b0, 1'b0, -1);
        end
        compared += 3;
        if (bus.count !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.count); end
        if (bus.overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_overrun: got %b expected 1", bus.overrun); end
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_frame_err: got %b expected 0", bus.frame_err); end
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i);
            compared++;
            if (bus.rd_data !== v) begin mismatched++; $display("[TB] FAIL fill_order_%0d: got %h expected %h", i, bus.rd_data, v); end
            pop_one();
        end
        compared++;
        if (bus.rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_drained: got %b expected 0", bus.rd_valid); end
        pulse_clr();
        compared++;
        if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_clr_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        compared += 2;
        if (bus.frame_err !== 1'b1) begin mismatched++; $display("[TB] FAIL ferr_flag: got %b expected 1", bus.frame_err); end
        if (bus.count !== 3'd0) begin mismatched++; $display("[TB] FAIL ferr_count: got %0d expected 0", bus.count); end
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (110) @(negedge clk);
        compared++;
        if (bus.count !== 3'd0) begin mismatched++; $display("[TB] FAIL ferr_break_retrigger: got count %0d expected 0", bus.count); end
        pulse_clr();
        compared++;
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ferr_clr: got %b expected 0", bus.frame_err); end
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, -1);
        compared += 2;
        if (bus.count !== 3'd1) begin mismatched++; $display("[TB] FAIL ferr_recover_count: got %0d expected 1", bus.count); end
        if (bus.rd_data !== 8'h7E) begin mismatched++; $display("[TB] FAIL ferr_recover_data: got %h expected 7e", bus.rd_data); end
    endtask

    task automatic test_glitch();
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        compared += 4;
        if (bus.count !== 3'd1) begin mismatched++; $display("[TB] FAIL glitch_count: got %0d expected 1", bus.count); end
        if (bus.rd_data !== 8'h7E) begin mismatched++; $display("[TB] FAIL glitch_data: got %h expected 7e", bus.rd_data); end
        if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_overrun: got %b expected 0", bus.overrun); end
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_frame_err: got %b expected 0", bus.frame_err); end
        pop_one();
        compared++;
        if (bus.rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_pop_valid: got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_full_pop_concurrent();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
        compared += 4;
        if (cnt_pre !== 3'd4) begin mismatched++; $display("[TB] FAIL fullpop_count_before: got %0d expected 4", cnt_pre); end
        if (cnt_post !== 3'd3) begin mismatched++; $display("[TB] FAIL fullpop_count_after: got %0d expected 3", cnt_post); end
        if (bus.overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL fullpop_overrun: got %b expected 1", bus.overrun); end
        if (bus.rd_data !== 8'h22) begin mismatched++; $display("[TB] FAIL fullpop_head: got %h expected 22", bus.rd_data); end
    endtask

    task automatic test_clr_coincident();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        rx = 1'b1;
        compared += 3;
        if (bus.frame_err !== 1'b1) begin mismatched++; $display("[TB] FAIL coincident_frame_err: got %b expected 1", bus.frame_err); end
        if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL coincident_overrun: got %b expected 0", bus.overrun); end
        if (bus.count !== 3'd3) begin mismatched++; $display("[TB] FAIL coincident_count: got %0d expected 3", bus.count); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 40);
        compared += 5;
        if (bus.rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_rd_data: got %h expected 00", bus.rd_data); end
        if (bus.rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_rd_valid: got %b expected 0", bus.rd_valid); end
        if (bus.count !== 3'd0) begin mismatched++; $display("[TB] FAIL midreset_count: got %0d expected 0", bus.count); end
        if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_overrun: got %b expected 0", bus.overrun); end
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_frame_err: got %b expected 0", bus.frame_err); end
        repeat (5) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, -1);
        compared += 3;
        if (bus.count !== 3'd1) begin mismatched++; $display("[TB] FAIL midreset_next_count: got %0d expected 1", bus.count); end
        if (bus.rd_data !== 8'hC3) begin mismatched++; $display("[TB] FAIL midreset_next_data: got %h expected c3", bus.rd_data); end
        if (bus.frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_next_frame_err: got %b expected 0", bus.frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overrun();
        test_frame_err();
        test_glitch();
        test_full_pop_concurrent();
        test_clr_coincident();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
